// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the decode-to-execute issue controller: widths, trap codes, FSM encoding.
package issue_ctrl_pkg;

  localparam int unsigned REG_W            = 5;
  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned CODE_W           = 8;
  localparam int unsigned PERF_W           = 32;
  localparam int unsigned MAX_INFLIGHT_DEF = 3;
  localparam int unsigned CNT_W_DEF        = 2;

  localparam logic [CODE_W-1:0] TRAP_SYSCALL         = 8'd8;
  localparam logic [CODE_W-1:0] TRAP_BAD_INSTRUCTION = 8'd10;

  typedef enum logic [1:0] {
    ISSUE_RUN   = 2'd0,
    ISSUE_DRAIN = 2'd1,
    ISSUE_TRAP  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Per-register in-flight write counters, total counter, two busy read ports and sticky retire error.
module issue_ctrl_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_wr,
  input  logic [REG_W-1:0] iss_rd,
  input  logic             ret,
  input  logic [REG_W-1:0] ret_rd,
  input  logic [REG_W-1:0] rd_a,
  input  logic [REG_W-1:0] rd_b,
  input  logic [REG_W-1:0] chk_rd,
  output logic             busy_a_c,
  output logic             busy_b_c,
  output logic             rd_full_c,
  output logic             total_full_c,
  output logic             drained_c,
  output logic             sb_err
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [CNT_W-1:0]    total;
  logic [CNT_W-1:0]    total_next;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                do_inc;
  logic                do_dec;
  logic                bad_ret;

  // Register 0 is never counted, so cnt[0] stays zero and reads as not busy.
  assign do_inc  = iss_wr && (iss_rd != '0);
  assign do_dec  = ret && (ret_rd != '0) && (cnt[ret_rd] != '0);
  assign bad_ret = ret && (ret_rd != '0) && (cnt[ret_rd] == '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (do_inc) inc_vec[iss_rd] = 1'b1;
    if (do_dec) dec_vec[ret_rd] = 1'b1;
  end

  always_comb begin
    total_next = total;
    if (do_inc && !do_dec)      total_next = total + CNT_W'(1);
    else if (do_dec && !do_inc) total_next = total - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      total  <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
      total <= total_next;
      if (bad_ret) sb_err <= 1'b1;
    end
  end

  assign busy_a_c     = (cnt[rd_a] != '0);
  assign busy_b_c     = (cnt[rd_b] != '0);
  assign rd_full_c    = (cnt[chk_rd] == CNT_W'(MAX_INFLIGHT));
  assign total_full_c = (total == CNT_W'(MAX_INFLIGHT));
  // Post-update total, so a trap can rise the cycle right after the last retire.
  assign drained_c    = (total_next == '0);

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: hazard/saturation stalls, redirect squash, drain-then-trap FSM and stall counter.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_W-1:0]  dec_rs,
  input  logic [REG_W-1:0]  dec_rt,
  input  logic [REG_W-1:0]  dec_rd,
  input  logic              dec_rs_used,
  input  logic              dec_rt_used,
  input  logic              dec_reg_write_en,
  input  logic [CODE_W-1:0] dec_exception,
  output logic              iss_valid,
  input  logic              ex_redirect,
  output logic              flush,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  output logic              trap_valid,
  output logic [CODE_W-1:0] trap_code,
  input  logic              trap_ack,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              sb_err
);

  issue_state_e      state, state_n;
  logic [CODE_W-1:0] trap_code_n;
  logic              trap_valid_n;
  logic              busy_rs, busy_rt, rd_full, total_full, drained;
  logic              hazard, saturated, stall_inc;

  issue_ctrl_scoreboard #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_wr       (iss_valid && dec_reg_write_en),
    .iss_rd       (dec_rd),
    .ret          (wb_valid),
    .ret_rd       (wb_rd),
    .rd_a         (dec_rs),
    .rd_b         (dec_rt),
    .chk_rd       (dec_rd),
    .busy_a_c     (busy_rs),
    .busy_b_c     (busy_rt),
    .rd_full_c    (rd_full),
    .total_full_c (total_full),
    .drained_c    (drained),
    .sb_err       (sb_err)
  );

  assign hazard    = (dec_rs_used && busy_rs) || (dec_rt_used && busy_rt);
  assign saturated = dec_reg_write_en && (rd_full || total_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ISSUE_RUN;
      trap_code  <= '0;
      trap_valid <= 1'b0;
    end else begin
      state      <= state_n;
      trap_code  <= trap_code_n;
      trap_valid <= trap_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    trap_code_n  = trap_code;
    trap_valid_n = trap_valid;
    dec_ready    = 1'b0;
    iss_valid    = 1'b0;
    flush        = 1'b0;
    unique case (state)
      ISSUE_RUN: begin
        if (ex_redirect) begin
          flush     = 1'b1;
          dec_ready = 1'b1;
        end else if (dec_valid && (dec_exception != '0)) begin
          dec_ready   = 1'b1;
          trap_code_n = dec_exception;
          if (drained) begin
            state_n      = ISSUE_TRAP;
            trap_valid_n = 1'b1;
          end else begin
            state_n = ISSUE_DRAIN;
          end
        end else begin
          iss_valid = dec_valid && !hazard && !saturated;
          dec_ready = iss_valid;
        end
      end
      ISSUE_DRAIN: begin
        // A redirect proves the excepting instruction was wrong-path.
        if (ex_redirect) begin
          flush       = 1'b1;
          trap_code_n = '0;
          state_n     = ISSUE_RUN;
        end else if (drained) begin
          state_n      = ISSUE_TRAP;
          trap_valid_n = 1'b1;
        end
      end
      ISSUE_TRAP: begin
        if (trap_ack) begin
          trap_valid_n = 1'b0;
          state_n      = ISSUE_RUN;
        end
      end
      default: state_n = ISSUE_RUN;
    endcase
  end

  assign stall_inc = (state == ISSUE_RUN) && dec_valid && !dec_ready && !ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stall_cycles <= '0;
    else if (stall_inc) stall_cycles <= stall_cycles + PERF_W'(1);
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: driver queues hand-computed per-cycle expectations, monitor compares.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  logic        dec_rs_used, dec_rt_used, dec_reg_write_en;
  logic [7:0]  dec_exception;
  logic        iss_valid, ex_redirect, flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        trap_valid, trap_ack;
  logic [7:0]  trap_code;
  logic [31:0] stall_cycles;
  logic        sb_err;

  typedef struct packed {
    logic        rdy;
    logic        iss;
    logic        fl;
    logic        tv;
    logic [7:0]  code;
    logic [31:0] stall;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  logic [31:0] exp_stall = '0;

  issue_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_rs           (dec_rs),
    .dec_rt           (dec_rt),
    .dec_rd           (dec_rd),
    .dec_rs_used      (dec_rs_used),
    .dec_rt_used      (dec_rt_used),
    .dec_reg_write_en (dec_reg_write_en),
    .dec_exception    (dec_exception),
    .iss_valid        (iss_valid),
    .ex_redirect      (ex_redirect),
    .flush            (flush),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .trap_valid       (trap_valid),
    .trap_code        (trap_code),
    .trap_ack         (trap_ack),
    .stall_cycles     (stall_cycles),
    .sb_err           (sb_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{dec_ready, iss_valid, flush, trap_valid, trap_code, stall_cycles, sb_err};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d: got rdy=%0b iss=%0b flush=%0b tv=%0b code=%0d stall=%0d err=%0b; required rdy=%0b iss=%0b flush=%0b tv=%0b code=%0d stall=%0d err=%0b",
                 cyc_n, a.rdy, a.iss, a.fl, a.tv, a.code, a.stall, a.err,
                 e.rdy, e.iss, e.fl, e.tv, e.code, e.stall, e.err);
      end
      cyc_n++;
    end
  end

  task automatic idle();
    dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_rd = 0;
    dec_rs_used = 0; dec_rt_used = 0; dec_reg_write_en = 0;
    dec_exception = 0; ex_redirect = 0; wb_valid = 0; wb_rd = 0; trap_ack = 0;
  endtask

  task automatic inst(input logic [4:0] rs, rt, rd, input logic rsu, rtu, we);
    dec_valid = 1; dec_rs = rs; dec_rt = rt; dec_rd = rd;
    dec_rs_used = rsu; dec_rt_used = rtu; dec_reg_write_en = we;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  // Queue this cycle's expectation (st = this cycle counts as a stall), then advance one clock.
  task automatic cyc(input logic rdy, iss, fl, tv, input logic [7:0] code, input logic st, err);
    exp_t e;
    e = '{rdy, iss, fl, tv, code, exp_stall, err};
    exp_q.push_back(e);
    if (st) exp_stall = exp_stall + 32'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    @(posedge clk); #1;
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0);
    rst_n = 1;

    // Load-use hazard on r8
    idle(); inst(1,0,8,1,0,1);         cyc(1,1,0,0,0,0,0);
    idle(); inst(8,0,9,1,0,0);         cyc(0,0,0,0,0,1,0);
    idle(); inst(8,0,9,1,0,0);         cyc(0,0,0,0,0,1,0);
    idle(); inst(8,0,9,1,0,0); wb(8);  cyc(0,0,0,0,0,1,0);
    idle(); inst(8,0,9,1,0,0);         cyc(1,1,0,0,0,0,0);

    // Register 0 is never busy
    idle(); inst(0,0,0,1,0,1);         cyc(1,1,0,0,0,0,0);
    idle(); inst(0,0,0,1,1,0);         cyc(1,1,0,0,0,0,0);

    // Saturation on r5, then total saturation blocks r6
    for (int i = 0; i < 3; i++) begin
      idle(); inst(0,0,5,0,0,1);       cyc(1,1,0,0,0,0,0);
    end
    idle(); inst(0,0,5,0,0,1);         cyc(0,0,0,0,0,1,0);
    idle(); inst(0,0,6,0,0,1);         cyc(0,0,0,0,0,1,0);
    idle(); inst(0,0,6,0,0,1); wb(5);  cyc(0,0,0,0,0,1,0);
    idle(); inst(0,0,6,0,0,1);         cyc(1,1,0,0,0,0,0);
    idle(); wb(5);                     cyc(0,0,0,0,0,0,0);
    idle(); wb(5);                     cyc(0,0,0,0,0,0,0);
    idle(); wb(6);                     cyc(0,0,0,0,0,0,0);

    // Same-cycle issue and retire of r9 leaves the count at 1
    idle(); inst(0,0,9,0,0,1);         cyc(1,1,0,0,0,0,0);
    idle(); inst(0,0,9,0,0,1); wb(9);  cyc(1,1,0,0,0,0,0);
    idle(); inst(9,0,1,1,0,0);         cyc(0,0,0,0,0,1,0);
    idle(); inst(9,0,1,1,0,0); wb(9);  cyc(0,0,0,0,0,1,0);
    idle(); inst(9,0,1,1,0,0);         cyc(1,1,0,0,0,0,0);

    // Syscall with two writes in flight
    idle(); inst(0,0,10,0,0,1);        cyc(1,1,0,0,0,0,0);
    idle(); inst(0,0,11,0,0,1);        cyc(1,1,0,0,0,0,0);
    idle(); inst(0,0,0,0,0,0); dec_exception = TRAP_SYSCALL;
                                       cyc(1,0,0,0,0,0,0);
    idle(); inst(0,0,1,0,0,0); wb(10); cyc(0,0,0,0,8,0,0);
    idle(); inst(0,0,1,0,0,0);         cyc(0,0,0,0,8,0,0);
    idle(); inst(0,0,1,0,0,0); wb(11); cyc(0,0,0,0,8,0,0);
    for (int i = 0; i < 3; i++) begin
      idle(); inst(0,0,1,0,0,0);       cyc(0,0,0,1,8,0,0);
    end
    idle(); inst(0,0,1,0,0,0); trap_ack = 1;
                                       cyc(0,0,0,1,8,0,0);
    idle(); inst(0,0,1,0,0,0);         cyc(1,1,0,0,8,0,0);

    // Bad instruction cancelled by redirect during drain
    idle(); inst(0,0,12,0,0,1);        cyc(1,1,0,0,8,0,0);
    idle(); inst(0,0,0,0,0,0); dec_exception = TRAP_BAD_INSTRUCTION;
                                       cyc(1,0,0,0,8,0,0);
    idle(); inst(0,0,1,0,0,0); ex_redirect = 1;
                                       cyc(0,0,1,0,10,0,0);
    idle(); wb(12);                    cyc(0,0,0,0,0,0,0);
    idle();                            cyc(0,0,0,0,0,0,0);

    // Redirect in RUN beats an exception
    idle(); inst(0,0,0,0,0,0); dec_exception = TRAP_SYSCALL; ex_redirect = 1;
                                       cyc(1,0,1,0,0,0,0);
    idle(); inst(0,0,1,0,0,0);         cyc(1,1,0,0,0,0,0);

    // Retire of empty r3 sets sticky sb_err until reset
    idle(); wb(3);                     cyc(0,0,0,0,0,0,0);
    idle();                            cyc(0,0,0,0,0,0,1);
    idle();                            cyc(0,0,0,0,0,0,1);
    idle(); rst_n = 0; exp_stall = '0; cyc(0,0,0,0,0,0,0);
    rst_n = 1;
    idle();                            cyc(0,0,0,0,0,0,0);

    // Reset mid-drain returns to RUN with an empty scoreboard
    idle(); inst(0,0,4,0,0,1);         cyc(1,1,0,0,0,0,0);
    idle(); inst(0,0,0,0,0,0); dec_exception = TRAP_SYSCALL;
                                       cyc(1,0,0,0,0,0,0);
    idle(); rst_n = 0;                 cyc(0,0,0,0,0,0,0);
    rst_n = 1;
    idle(); inst(4,0,1,1,0,0);         cyc(1,1,0,0,0,0,0);
    idle();                            cyc(0,0,0,0,0,0,0);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
